// File: rtl/mem_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : mem_scoreboard
// Description : End-of-run data-memory checker. It mirrors every D-cache
//               write-through into a shadow RAM. When the program ends (the PC
//               reaches a threshold) or a cycle budget runs out, it compares
//               every shadow word against an external golden store. It reports
//               a saturating error count, the first failing address, the run
//               duration and pass/finish flags.
// Ports       : clk, rst            clock, asynchronous active-high reset
//               start               1-cycle pulse, INIT -> RUN
//               wen/addr/data       shadow write port (preload + CPU writes)
//               pc                  CPU program counter (end-of-run detect)
//               gold_addr/gold_data golden-store read (data 1 cycle later)
//               error_num           saturating mismatch count
//               first_err_valid/_addr  first mismatch record
//               cycles, timeout     run length, run ended by cycle budget
//               finish, pass        sticky completion / verdict
// Revision    : 1.0 - initial release
// ============================================================================
module mem_scoreboard #(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned END_PC  = 400,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned CW      = 16,
    parameter int unsigned EW      = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic [31:0]   pc,
    output logic [AW-1:0] gold_addr,
    input  logic [DW-1:0] gold_data,
    output logic [EW-1:0] error_num,
    output logic          first_err_valid,
    output logic [AW-1:0] first_err_addr,
    output logic [CW-1:0] cycles,
    output logic          timeout,
    output logic          finish,
    output logic          pass
);

    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [2:0] c_st_init   = 3'd0;
    localparam logic [2:0] c_st_run    = 3'd1;
    localparam logic [2:0] c_st_check  = 3'd2;
    localparam logic [2:0] c_st_report = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic [CW-1:0] c_timeout_last = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] c_cycles_max   = '1;
    localparam logic [EW-1:0] c_err_max      = '1;
    localparam logic [AW-1:0] c_last_addr    = '1;
    localparam logic [31:0]   c_end_pc       = 32'(END_PC);

    logic [2:0]    r_state;
    logic [DW-1:0] r_shadow [DEPTH];
    logic [DW-1:0] r_shadow_q;      // shadow word issued last cycle
    logic [AW-1:0] r_cmp_addr;      // address of r_shadow_q
    logic          r_cmp_valid;     // r_shadow_q/gold_data pair is live
    logic          r_draining;      // last address issued, final compare pending
    logic [AW-1:0] r_gold_addr;
    logic [EW-1:0] r_error_num;
    logic          r_first_err_valid;
    logic [AW-1:0] r_first_err_addr;
    logic [CW-1:0] r_cycles;
    logic          r_timeout;
    logic          r_finish;
    logic          r_pass;

    logic          w_shadow_wr;
    logic [DW-1:0] w_shadow_rd;
    logic          w_mismatch;

    // The shadow only tracks memory while the program can still change it;
    // once the check starts it is frozen so the compare sees a stable image.
    assign w_shadow_wr = wen && ((r_state == c_st_init) || (r_state == c_st_run));
    assign w_shadow_rd = r_shadow[r_gold_addr];

    // Case inequality so that X/Z in either word is reported as a mismatch
    // in simulation; synthesis treats it as a plain inequality.
    assign w_mismatch  = r_cmp_valid && (r_shadow_q !== gold_data);

    // Shadow RAM is deliberately not reset: its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_shadow_wr) begin
            r_shadow[addr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= c_st_init;
            r_shadow_q        <= '0;
            r_cmp_addr        <= '0;
            r_cmp_valid       <= 1'b0;
            r_draining        <= 1'b0;
            r_gold_addr       <= '0;
            r_error_num       <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_addr  <= '0;
            r_cycles          <= '0;
            r_timeout         <= 1'b0;
            r_finish          <= 1'b0;
            r_pass            <= 1'b0;
        end else begin
            case (r_state)
                c_st_init: begin
                    if (start) begin
                        r_state <= c_st_run;
                    end
                end

                c_st_run: begin
                    if (r_cycles != c_cycles_max) begin
                        r_cycles <= r_cycles + CW'(1);
                    end
                    // Program end takes priority over the cycle budget.
                    if (pc >= c_end_pc) begin
                        r_state <= c_st_check;
                    end else if (r_cycles == c_timeout_last) begin
                        r_state   <= c_st_check;
                        r_timeout <= 1'b1;
                    end
                end

                c_st_check: begin
                    // Issue one address per cycle; the golden word for it
                    // arrives next cycle alongside the registered shadow word.
                    r_shadow_q  <= w_shadow_rd;
                    r_cmp_addr  <= r_gold_addr;
                    r_cmp_valid <= !r_draining;
                    if (r_draining) begin
                        r_state <= c_st_report;
                    end else if (r_gold_addr == c_last_addr) begin
                        r_draining <= 1'b1;
                    end else begin
                        r_gold_addr <= r_gold_addr + AW'(1);
                    end
                end

                c_st_report: begin
                    r_finish <= 1'b1;
                    r_pass   <= (r_error_num == '0) && !r_timeout;
                    r_state  <= c_st_done;
                end

                c_st_done: begin
                    r_state <= c_st_done;
                end

                default: begin
                    r_state <= c_st_init;
                end
            endcase

            if (w_mismatch) begin
                if (r_error_num != c_err_max) begin
                    r_error_num <= r_error_num + EW'(1);
                end
                if (!r_first_err_valid) begin
                    r_first_err_valid <= 1'b1;
                    r_first_err_addr  <= r_cmp_addr;
                end
            end
        end
    end

    assign gold_addr       = r_gold_addr;
    assign error_num       = r_error_num;
    assign first_err_valid = r_first_err_valid;
    assign first_err_addr  = r_first_err_addr;
    assign cycles          = r_cycles;
    assign timeout         = r_timeout;
    assign finish          = r_finish;
    assign pass            = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_mem_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_scoreboard
// Description : Randomized self-checking bench for mem_scoreboard. Two
//               instances share the stimulus: a main one (EW=9) and one with a
//               2-bit error counter whose golden image is fully inverted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_scoreboard;

    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int DEPTH   = 256;
    localparam int END_PC  = 400;
    localparam int TIMEOUT = 100;
    localparam int CW      = 16;
    localparam int EW      = 9;
    localparam int EW_SAT  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   pc;

    logic [AW-1:0] gold_addr_m, first_err_addr_m, ga_m_q;
    logic [DW-1:0] gold_data_m;
    logic [EW-1:0] error_num_m;
    logic          first_err_valid_m, timeout_m, finish_m, pass_m;
    logic [CW-1:0] cycles_m;

    logic [AW-1:0]     gold_addr_s, first_err_addr_s, ga_s_q;
    logic [DW-1:0]     gold_data_s;
    logic [EW_SAT-1:0] error_num_s;
    logic              first_err_valid_s, timeout_s, finish_s, pass_s;
    logic [CW-1:0]     cycles_s;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] gold_main [DEPTH];
    logic [DW-1:0] gold_sat  [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Golden store: word for an address is presented one cycle after it.
    always @(posedge clk) begin
        ga_m_q <= gold_addr_m;
        ga_s_q <= gold_addr_s;
    end
    assign gold_data_m = gold_main[ga_m_q];
    assign gold_data_s = gold_sat[ga_s_q];

    mem_scoreboard #(.AW(AW), .DW(DW), .END_PC(END_PC), .TIMEOUT(TIMEOUT),
                     .CW(CW), .EW(EW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .wen(wen), .addr(addr), .data(data),
        .pc(pc), .gold_addr(gold_addr_m), .gold_data(gold_data_m),
        .error_num(error_num_m), .first_err_valid(first_err_valid_m),
        .first_err_addr(first_err_addr_m), .cycles(cycles_m), .timeout(timeout_m),
        .finish(finish_m), .pass(pass_m)
    );

    mem_scoreboard #(.AW(AW), .DW(DW), .END_PC(END_PC), .TIMEOUT(TIMEOUT),
                     .CW(CW), .EW(EW_SAT)) u_sat (
        .clk(clk), .rst(rst), .start(start), .wen(wen), .addr(addr), .data(data),
        .pc(pc), .gold_addr(gold_addr_s), .gold_data(gold_data_s),
        .error_num(error_num_s), .first_err_valid(first_err_valid_s),
        .first_err_addr(first_err_addr_s), .cycles(cycles_s), .timeout(timeout_s),
        .finish(finish_s), .pass(pass_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_gold_addr"},  64'(gold_addr_m), 64'd0);
        chk({pfx, "_error_num"},  64'(error_num_m), 64'd0);
        chk({pfx, "_first_vld"},  64'(first_err_valid_m), 64'd0);
        chk({pfx, "_first_addr"}, 64'(first_err_addr_m), 64'd0);
        chk({pfx, "_cycles"},     64'(cycles_m), 64'd0);
        chk({pfx, "_timeout"},    64'(timeout_m), 64'd0);
        chk({pfx, "_finish"},     64'(finish_m), 64'd0);
        chk({pfx, "_pass"},       64'(pass_m), 64'd0);
        chk({pfx, "_sat_err"},    64'(error_num_s), 64'd0);
    endtask

    task automatic drive_junk();
        wen   = 1'($urandom);
        start = 1'($urandom);
        addr  = AW'($urandom);
        data  = $urandom;
        pc    = $urandom;
    endtask

    // pc_cycle: RUN cycle on which pc first reaches END_PC (-1 = never).
    // f0/f1: golden addresses to corrupt (-1 = none). abort: reset at i=50.
    task automatic run_test(input int pc_cycle, input int f0, input int f1, input bit abort);
        int  exit_c;
        bit  exp_to;
        int  exp_err;
        int  exp_first;
        bit  found;
        int  k;
        bit  aborted;

        @(negedge clk);
        rst = 1'b1; wen = 1'b0; start = 1'b0; pc = '0; addr = '0; data = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // INIT: preload the full image; start arrives with the last write.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wen   = 1'b1;
            addr  = AW'(i);
            data  = $urandom;
            model_mem[i] = data;
            start = (i == DEPTH - 1);
            pc    = 32'($urandom_range(0, END_PC - 1));
        end

        // RUN: random CPU writes; the exit cycle always writes address 7.
        exit_c = -1;
        exp_to = 1'b0;
        for (int c = 0; exit_c < 0; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            if (pc_cycle >= 0 && c >= pc_cycle)
                pc = ($urandom_range(0, 1) == 1) ? (32'h8000_0000 | $urandom)
                                                 : 32'(END_PC + $urandom_range(0, 1000));
            else
                pc = 32'($urandom_range(0, END_PC - 1));
            wen  = ($urandom_range(0, 3) == 0) || (c == pc_cycle) || (c == TIMEOUT - 1);
            addr = (c == pc_cycle || c == TIMEOUT - 1) ? AW'(7) : AW'($urandom);
            data = $urandom;
            if (wen) model_mem[addr] = data;
            if (pc >= 32'(END_PC)) begin
                exit_c = c; exp_to = 1'b0;
            end else if (c == TIMEOUT - 1) begin
                exit_c = c; exp_to = 1'b1;
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            gold_main[i] = model_mem[i];
            gold_sat[i]  = ~model_mem[i];
        end
        if (f0 >= 0) gold_main[f0] = model_mem[f0] ^ (32'd1 << $urandom_range(0, 31));
        if (f1 >= 0) gold_main[f1] = model_mem[f1] ^ (32'd1 << $urandom_range(0, 31));

        exp_err = 0; exp_first = 0; found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gold_main[i] !== model_mem[i]) begin
                exp_err++;
                if (!found) begin exp_first = i; found = 1'b1; end
            end
        end

        // CHECK: wait (bounded) for finish while throwing ignored junk at the inputs.
        k = 0;
        aborted = 1'b0;
        forever begin
            @(negedge clk);
            if (finish_m || k > 600) break;
            if (abort && gold_addr_m == AW'(50)) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs("abort");
                #1 rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            drive_junk();
            k++;
        end

        if (abort) begin
            chk("abort_reached", 64'(aborted), 64'd1);
        end else begin
            chk("finish",        64'(finish_m), 64'd1);
            chk("check_latency", 64'(k), 64'(DEPTH + 2));
            chk("error_num",     64'(error_num_m), 64'(exp_err));
            chk("first_vld",     64'(first_err_valid_m), 64'(found));
            chk("first_addr",    64'(first_err_addr_m), 64'(exp_first));
            chk("cycles",        64'(cycles_m), 64'(exit_c + 1));
            chk("timeout",       64'(timeout_m), 64'(exp_to));
            chk("pass",          64'(pass_m), 64'((exp_err == 0) && !exp_to));
            chk("sat_err",       64'(error_num_s), 64'd3);
            chk("sat_first_vld", 64'(first_err_valid_s), 64'd1);
            chk("sat_first",     64'(first_err_addr_s), 64'd0);
            chk("sat_pass",      64'(pass_s), 64'd0);
            chk("sat_finish",    64'(finish_s), 64'd1);
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                drive_junk();
            end
            @(negedge clk);
            chk("hold_finish",   64'(finish_m), 64'd1);
            chk("hold_err",      64'(error_num_m), 64'(exp_err));
            chk("hold_cycles",   64'(cycles_m), 64'(exit_c + 1));
            chk("hold_pass",     64'(pass_m), 64'((exp_err == 0) && !exp_to));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; wen = 1'b0; addr = '0; data = '0; pc = '0;

        run_test(10, -1, -1, 1'b0);          // clean run, pc exit
        run_test(20, 5, 200, 1'b0);          // two corrupted words
        run_test(-1, -1, -1, 1'b0);          // timeout with no errors
        run_test(TIMEOUT - 1, -1, -1, 1'b0); // pc and budget coincide
        run_test(30, -1, -1, 1'b1);          // reset mid-check
        run_test(15, -1, -1, 1'b0);          // clean run after abort
        for (int r = 0; r < 3; r++) begin
            run_test($urandom_range(0, 120),
                     ($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH - 1) : -1,
                     $urandom_range(0, DEPTH - 1), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
